// File: rtl/ct_ciu_ebiuif_crcd_sched_pkg.sv
// Shared CIU definitions for the CR/CD snoop-response scheduler.
// Latency: n/a (constants only).
// Backpressure: n/a.
package ct_ciu_ebiuif_crcd_sched_pkg;

  // Snoop source identifiers as stored in the CR order queue
  localparam logic [1:0] SRC_SNB0 = 2'd0;
  localparam logic [1:0] SRC_SNB1 = 2'd1;
  localparam logic [1:0] SRC_CTCQ = 2'd2;

  // CRRESP bit positions
  localparam int DATA_TRANSFER = 0;
  localparam int ERROR         = 1;
  localparam int PASS_DIRTY    = 2;
  localparam int IS_SHARED     = 3;
  localparam int WAS_UNIQUE    = 4;

  // Default depth of both order queues
  localparam int CR_DEPTH_DFLT = 4;

endpackage

// File: rtl/ct_ciu_crcd_order_fifo.sv
// Order FIFO holding source IDs; head is read straight from storage flops.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: caller must not push when full or pop when empty.
module ct_ciu_crcd_order_fifo #(
  parameter int ID_W  = 2,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic [ID_W-1:0] push_id,
  input  logic            pop,
  output logic [ID_W-1:0] head_id,
  output logic            full,
  output logic            empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ID_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  // Storage, pointers (wrap naturally at power-of-two depth) and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_id;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head_id = mem[rd_ptr];
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);

endmodule

// File: rtl/ct_ciu_ebiuif_crcd_sched.sv
// Returns snoop CR in AC-grant order and CD in data-CR order to the EBIU (CTCQ source under CIU_CTC_SNOOP_EN).
// Latency: queued IDs reach the head one cycle after push; source-to-EBIU paths are combinational.
// Backpressure: sched_ac_stall when CR queue full; data CR held while CD queue full.
module ct_ciu_ebiuif_crcd_sched
  import ct_ciu_ebiuif_crcd_sched_pkg::*;
#(
  parameter int CR_DEPTH = CR_DEPTH_DFLT
) (
  input  logic         forever_cpuclk,
  input  logic         cpurst,
  input  logic [2:0]   ac_grant_id,
  input  logic         snb0_crvalid,
  input  logic         snb1_crvalid,
  input  logic         ctcq_crvalid,
  input  logic [4:0]   snb0_crresp,
  input  logic [4:0]   snb1_crresp,
  input  logic [4:0]   ctcq_crresp,
  output logic         sched_snb0_cr_grant,
  output logic         sched_snb1_cr_grant,
  output logic         sched_ctcq_cr_grant,
  input  logic         snb0_cdvalid,
  input  logic         snb1_cdvalid,
  input  logic [127:0] snb0_cddata,
  input  logic [127:0] snb1_cddata,
  input  logic         snb0_cdlast,
  input  logic         snb1_cdlast,
  output logic         sched_snb0_cd_grant,
  output logic         sched_snb1_cd_grant,
  output logic         ebiuif_ebiu_crvalid,
  output logic [4:0]   ebiuif_ebiu_crresp,
  input  logic         ebiu_ebiuif_cr_grant,
  output logic         ebiuif_ebiu_cdvalid,
  output logic [127:0] ebiuif_ebiu_cddata,
  output logic         ebiuif_ebiu_cdlast,
  input  logic         ebiu_ebiuif_cd_grant,
  output logic         sched_ac_stall
);

  logic       cr_push, cr_pop, cr_full, cr_empty;
  logic [1:0] cr_push_id, cr_src;
  logic       cd_push, cd_pop, cd_full, cd_empty;
  logic       cd_src;
  logic       src_crvalid;
  logic [4:0] src_crresp;
  logic       cr_is_data, cd_block, cr_hs, cd_hs;

  // Encode the one-hot AC grant into a queued source ID
  always_comb begin
    cr_push    = 1'b0;
    cr_push_id = SRC_SNB0;
    if (ac_grant_id[0]) begin
      cr_push    = 1'b1;
      cr_push_id = SRC_SNB0;
    end else if (ac_grant_id[1]) begin
      cr_push    = 1'b1;
      cr_push_id = SRC_SNB1;
    end
`ifdef CIU_CTC_SNOOP_EN
    else if (ac_grant_id[2]) begin
      cr_push    = 1'b1;
      cr_push_id = SRC_CTCQ;
    end
`endif
  end

  ct_ciu_crcd_order_fifo #(.ID_W(2), .DEPTH(CR_DEPTH)) u_cr_q (
    .clk     (forever_cpuclk),
    .rst     (cpurst),
    .push    (cr_push),
    .push_id (cr_push_id),
    .pop     (cr_pop),
    .head_id (cr_src),
    .full    (cr_full),
    .empty   (cr_empty)
  );

  // Select the CR source named by the CR queue head
  always_comb begin
    src_crvalid = 1'b0;
    src_crresp  = '0;
    case (cr_src)
      SRC_SNB0: begin src_crvalid = snb0_crvalid; src_crresp = snb0_crresp; end
      SRC_SNB1: begin src_crvalid = snb1_crvalid; src_crresp = snb1_crresp; end
`ifdef CIU_CTC_SNOOP_EN
      SRC_CTCQ: begin src_crvalid = ctcq_crvalid; src_crresp = ctcq_crresp; end
`endif
      default: ;
    endcase
  end

  // CTCQ never returns snoop data through this block, so only snb responses count as data
  assign cr_is_data = src_crresp[DATA_TRANSFER] && (cr_src != SRC_CTCQ);
  assign cd_block   = cr_is_data && cd_full;

  assign ebiuif_ebiu_crvalid = !cr_empty && src_crvalid && !cd_block;
  assign ebiuif_ebiu_crresp  = cr_empty ? 5'd0 : src_crresp;
  assign cr_hs               = ebiuif_ebiu_crvalid && ebiu_ebiuif_cr_grant;
  assign cr_pop              = cr_hs;

  assign sched_snb0_cr_grant = cr_hs && (cr_src == SRC_SNB0);
  assign sched_snb1_cr_grant = cr_hs && (cr_src == SRC_SNB1);
`ifdef CIU_CTC_SNOOP_EN
  assign sched_ctcq_cr_grant = cr_hs && (cr_src == SRC_CTCQ);
`else
  assign sched_ctcq_cr_grant = 1'b0;
  logic unused_ctcq;
  assign unused_ctcq = ^{ctcq_crvalid, ctcq_crresp};
`endif

  assign sched_ac_stall = cr_full;

  // A data-carrying CR records its source so CD follows CR order
  assign cd_push = cr_hs && cr_is_data;

  ct_ciu_crcd_order_fifo #(.ID_W(1), .DEPTH(CR_DEPTH)) u_cd_q (
    .clk     (forever_cpuclk),
    .rst     (cpurst),
    .push    (cd_push),
    .push_id (cr_src[0]),
    .pop     (cd_pop),
    .head_id (cd_src),
    .full    (cd_full),
    .empty   (cd_empty)
  );

  // Forward the CD beat of the source at the CD queue head
  always_comb begin
    ebiuif_ebiu_cdvalid = 1'b0;
    ebiuif_ebiu_cddata  = '0;
    ebiuif_ebiu_cdlast  = 1'b0;
    if (!cd_empty) begin
      if (cd_src) begin
        ebiuif_ebiu_cdvalid = snb1_cdvalid;
        ebiuif_ebiu_cddata  = snb1_cddata;
        ebiuif_ebiu_cdlast  = snb1_cdlast;
      end else begin
        ebiuif_ebiu_cdvalid = snb0_cdvalid;
        ebiuif_ebiu_cddata  = snb0_cddata;
        ebiuif_ebiu_cdlast  = snb0_cdlast;
      end
    end
  end

  assign cd_hs               = ebiuif_ebiu_cdvalid && ebiu_ebiuif_cd_grant;
  assign cd_pop              = cd_hs && ebiuif_ebiu_cdlast;
  assign sched_snb0_cd_grant = cd_hs && !cd_src;
  assign sched_snb1_cd_grant = cd_hs && cd_src;

  // Upstream contract: at most one AC per cycle and none while stalled
  a_ac_onehot: assert property (@(posedge forever_cpuclk) disable iff (cpurst)
    $onehot0(ac_grant_id));
  a_ac_no_push_stalled: assert property (@(posedge forever_cpuclk) disable iff (cpurst)
    !((ac_grant_id != 3'd0) && sched_ac_stall));

endmodule

// File: doc/ct_ciu_ebiuif_crcd_sched.md
# ct_ciu_ebiuif_crcd_sched

Snoop-response scheduler for the CIU external bus interface. It returns CR (snoop response) and CD (snoop data) from the snoop buffers (snb0, snb1) and the CTC queue to the EBIU. Ordering is ACE-compliant: CR follows AC grant order, and CD follows the order of the CRs that carried data. It sits between the AC-grant/snoop sources and the EBIU CR/CD channels. Its queue-full indication replaces the tied-off `cr_sel_full` term in the AC valid gating.

## Interface
Parameters:
- CR_DEPTH, 4: entries in the CR order queue and in the CD order queue (power of two, ≥2).

Ports:
- forever_cpuclk  in  1  clock
- cpurst  in  1  asynchronous, active-high reset
- ac_grant_id  in  3  one-hot accepted AC this cycle: {ctcq, snb1, snb0}; all-zero = none
- snb0_crvalid / snb1_crvalid / ctcq_crvalid  in  1 each  source CR valid
- snb0_crresp / snb1_crresp / ctcq_crresp  in  5 each  source CR response; bit0 = DataTransfer
- sched_snb0_cr_grant / sched_snb1_cr_grant / sched_ctcq_cr_grant  out  1 each  CR accepted from source
- snb0_cdvalid / snb1_cdvalid  in  1 each  source CD beat valid
- snb0_cddata / snb1_cddata  in  128 each  CD beat data
- snb0_cdlast / snb1_cdlast  in  1 each  last CD beat
- sched_snb0_cd_grant / sched_snb1_cd_grant  out  1 each  CD beat accepted
- ebiuif_ebiu_crvalid  out  1;  ebiuif_ebiu_crresp  out  5;  ebiu_ebiuif_cr_grant  in  1
- ebiuif_ebiu_cdvalid  out  1;  ebiuif_ebiu_cddata  out  128;  ebiuif_ebiu_cdlast  out  1;  ebiu_ebiuif_cd_grant  in  1
- sched_ac_stall  out  1  CR queue full; upstream must suppress all AC valids

## Operation
- CR queue: FIFO of 2-bit source IDs (snb0 = 0, snb1 = 1, ctcq = 2).
  - Push the encoded ID when ac_grant_id ≠ 0.
  - Head entry selects the CR source. crvalid = head valid & selected source crvalid; crresp comes from the selected source.
  - CR handshake = crvalid & cr_grant. On a handshake: pulse the head source's cr_grant and pop.
- CD queue: FIFO of 1-bit source IDs.
  - Push on a CR handshake with crresp[0]=1 from snb0/snb1.
  - CTCQ crresp[0] is ignored: CTCQ never pushes to the CD queue.
  - Head selects the CD source. cdvalid/cddata/cdlast are muxed from it. On cdvalid & cd_grant, grant the source.
  - Pop on a handshake with cdlast=1.
- CD back-pressure: if the head CR has crresp[0]=1 and the CD queue is full, hold crvalid low.
- sched_ac_stall = CR count == CR_DEPTH. It is count-based with no same-cycle pop bypass.
- Outputs are zero/idle whenever the corresponding queue is empty. Non-head sources never see a grant.
- Simultaneous push and pop: allowed on both queues; count is unchanged.
- Reset mid-operation: both queues empty immediately. In-flight CR/CD beats are dropped; the upstream is reset with the same reset.
- Illegal inputs, flagged by assertion: multi-hot ac_grant_id; ac_grant_id ≠ 0 while sched_ac_stall=1.

## Timing
- Reset values: all outputs 0; both queues empty; read/write pointers and counts 0.
- AC grant in cycle N: the entry is at head no earlier than N+1. No same-cycle bypass.
- CR data-response handshake in cycle N: the CD source may be granted from N+1.
- Combinational paths:
  - source crvalid/crresp → ebiuif_ebiu_crvalid/crresp
  - ebiu cr_grant → sched_*_cr_grant
  - the same pair of paths for CD
- Head-ID multiplexers are driven from flops only.
- Pointers wrap modulo CR_DEPTH. Counts are log2(CR_DEPTH)+1 bits wide.
- Sources hold valid/payload stable until granted. The block relies on this and does not register payload.

## Configuration
- CIU_CTC_SNOOP_EN
  - Defined: CTCQ is a full CR source as described above.
  - Undefined: ac_grant_id[2] is ignored; sched_ctcq_cr_grant is tied 0; ctcq_crvalid/ctcq_crresp are unused; ID value 2 is never written.

## Structure
- Shared CIU package holds:
  - source ID encodings: SRC_SNB0 = 2'd0, SRC_SNB1 = 2'd1, SRC_CTCQ = 2'd2
  - CRRESP bit indices: DATA_TRANSFER = 0, ERROR = 1, PASS_DIRTY = 2, IS_SHARED = 3, WAS_UNIQUE = 4
  - default CR_DEPTH
- One sub-module, ct_ciu_crcd_order_fifo: parameterised ID width and depth, with push/pop/head/full/empty. It is instantiated twice: CR queue with 2-bit IDs, CD queue with 1-bit IDs.

## Test plan
- AC grants snb0, snb1, ctcq in cycles 1–3; sources assert crvalid in reverse order → CR handshakes occur strictly in order snb0, snb1, ctcq, each granting only the matching source.
- snb1 CR 5'b00001 then snb0 CR 5'b00001; snb0 asserts cdvalid first → no snb0 cd_grant until snb1's 4-beat CD completes with cdlast; then snb0 CD proceeds.
- Four AC grants with no CR (CR_DEPTH=4) → sched_ac_stall=1 from the cycle after the 4th push; one CR handshake → stall=0 the following cycle.
- Fill the CD queue with 4 data responses, hold cd_grant=0 → next data-carrying head CR has crvalid=0; first cdlast grant → crvalid=1 next cycle.
- ctcq CR with crresp=5'b00001 → CR forwarded; CD queue count unchanged; no CD activity.
- Assert cpurst mid-CD burst (beat 2 of 4) → all outputs 0 in the same cycle; after release, a fresh AC/CR sequence behaves as from empty.
